// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// the carry out of each add becomes a single-cycle enable pulse and toggles a square wave.
module clk_en_gen #(
  parameter int                     CHANNELS  = 2,
  parameter int                     ACC_W     = 16,
  parameter int unsigned            INC_RESET = 7820,
  parameter logic [CHANNELS-1:0]    RUN_RESET = '1,
  localparam int                    SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iSync,
  input  logic                iWrEn,
  input  logic [SEL_W-1:0]    iWrSel,
  input  logic                iWrReg,
  input  logic [ACC_W-1:0]    iWrData,
  output logic [CHANNELS-1:0] oClkEn,
  output logic [CHANNELS-1:0] oSq,
  output logic [CHANNELS-1:0] oRunning
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      localparam logic [SEL_W-1:0] CH_SEL = SEL_W'(gi);

      logic [ACC_W-1:0] acc_q, acc_d;
      logic [ACC_W-1:0] inc_q, inc_d;
      logic             run_q, run_d;
      logic             os_q, os_d;
      logic             en_q, en_d;
      logic             sq_q, sq_d;
      logic [ACC_W:0]   sum;
      logic             hit, ctrl_wr, inc_wr, stop_wr, start_wr, pulse;

      // Out-of-range selects never match any channel, so they fall through harmlessly.
      assign hit      = iWrEn && (iWrSel == CH_SEL);
      assign ctrl_wr  = hit && iWrReg;
      assign inc_wr   = hit && !iWrReg;
      assign stop_wr  = ctrl_wr && !iWrData[0];
      assign start_wr = ctrl_wr && iWrData[0] && !run_q;
      assign sum      = {1'b0, acc_q} + {1'b0, inc_q};
      assign pulse    = run_q && sum[ACC_W] && !iSync && !stop_wr;

      always_comb begin
        acc_d = acc_q;
        if (iSync || start_wr) begin
          acc_d = '0;
        end else if (run_q && !stop_wr) begin
          acc_d = sum[ACC_W-1:0];
        end

        sq_d = sq_q;
        if (start_wr) begin
          sq_d = 1'b0;
        end else if (pulse) begin
          sq_d = ~sq_q;
        end

        // A control write wins over the oneshot self-clear on the same edge.
        run_d = run_q;
        if (ctrl_wr) begin
          run_d = iWrData[0];
        end else if (pulse && os_q) begin
          run_d = 1'b0;
        end

        os_d  = ctrl_wr ? iWrData[1] : os_q;
        inc_d = inc_wr ? iWrData : inc_q;
        en_d  = pulse;
      end

      always_ff @(posedge iClk) begin
        if (iRst) begin
          acc_q <= '0;
          inc_q <= ACC_W'(INC_RESET);
          run_q <= RUN_RESET[gi];
          os_q  <= 1'b0;
          en_q  <= 1'b0;
          sq_q  <= 1'b0;
        end else begin
          acc_q <= acc_d;
          inc_q <= inc_d;
          run_q <= run_d;
          os_q  <= os_d;
          en_q  <= en_d;
          sq_q  <= sq_d;
        end
      end

      assign oClkEn[gi]   = en_q;
      assign oSq[gi]      = sq_q;
      assign oRunning[gi] = run_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_en_gen.sv
// Randomized bench for clk_en_gen: a rule-level reference model is checked every cycle,
// plus directed scenarios for pulse rate, oneshot, write timing, sync and reset.
module tb_clk_en_gen;

  localparam int     NCH = 3;
  localparam longint MOD = 65536;

  logic        iClk = 1'b0;
  logic        iRst, iSync, iWrEn, iWrReg;
  logic [1:0]  iWrSel;
  logic [15:0] iWrData;
  logic [2:0]  oClkEn, oSq, oRunning;

  logic        s_sync, s_wren, s_wrsel, s_wrreg;
  logic [9:0]  s_data;
  logic        s_en, s_sq, s_run;

  int num_cmp = 0;
  int num_err = 0;

  longint m_acc [NCH];
  longint m_inc [NCH];
  bit     m_run [NCH];
  bit     m_os  [NCH];
  bit     m_sq  [NCH];
  bit     m_en  [NCH];

  always #5 iClk = ~iClk;

  clk_en_gen #(.CHANNELS(3), .ACC_W(16), .INC_RESET(7820), .RUN_RESET(3'b111)) dut (
    .iClk(iClk), .iRst(iRst), .iSync(iSync), .iWrEn(iWrEn), .iWrSel(iWrSel),
    .iWrReg(iWrReg), .iWrData(iWrData), .oClkEn(oClkEn), .oSq(oSq), .oRunning(oRunning)
  );

  clk_en_gen #(.CHANNELS(1), .ACC_W(10), .INC_RESET(122), .RUN_RESET(1'b1)) dut_small (
    .iClk(iClk), .iRst(iRst), .iSync(s_sync), .iWrEn(s_wren), .iWrSel(s_wrsel),
    .iWrReg(s_wrreg), .iWrData(s_data), .oClkEn(s_en), .oSq(s_sq), .oRunning(s_run)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_cmp++;
    if (got !== exp) begin
      num_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies the behavioural rules to the inputs present at the current edge.
  task automatic model_edge();
    for (int ch = 0; ch < NCH; ch++) begin
      bit wr, ctrl, incw, fires, nrun;
      longint tot;
      if (iRst) begin
        m_acc[ch] = 0; m_inc[ch] = 7820; m_run[ch] = 1'b1;
        m_os[ch] = 1'b0; m_sq[ch] = 1'b0; m_en[ch] = 1'b0;
      end else begin
        wr    = iWrEn && (int'(iWrSel) == ch);
        ctrl  = wr && iWrReg;
        incw  = wr && !iWrReg;
        nrun  = ctrl ? iWrData[0] : m_run[ch];
        fires = 1'b0;
        if (m_run[ch] && !iSync && !(ctrl && !iWrData[0])) begin
          tot       = m_acc[ch] + m_inc[ch];
          fires     = (tot >= MOD);
          m_acc[ch] = tot % MOD;
        end
        if (iSync) m_acc[ch] = 0;
        if (ctrl && iWrData[0] && !m_run[ch]) begin
          m_acc[ch] = 0;
          m_sq[ch]  = 1'b0;
        end
        if (fires) begin
          m_sq[ch] = ~m_sq[ch];
          if (m_os[ch] && !ctrl) nrun = 1'b0;
        end
        if (ctrl) m_os[ch] = iWrData[1];
        if (incw) m_inc[ch] = longint'(iWrData);
        m_run[ch] = nrun;
        m_en[ch]  = fires;
      end
    end
  endtask

  task automatic step();
    logic [2:0] e_en, e_sq, e_run;
    @(posedge iClk);
    model_edge();
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      e_en[ch] = m_en[ch]; e_sq[ch] = m_sq[ch]; e_run[ch] = m_run[ch];
    end
    check("clken", 32'(oClkEn), 32'(e_en));
    check("sq", 32'(oSq), 32'(e_sq));
    check("running", 32'(oRunning), 32'(e_run));
  endtask

  task automatic wr(input int sel, input bit rg, input logic [15:0] d);
    iWrEn = 1'b1; iWrSel = 2'(sel); iWrReg = rg; iWrData = d;
    step();
    iWrEn = 1'b0;
  endtask

  initial begin
    int cnt;
    logic prev;
    longint a, b;
    iRst = 1'b1; iSync = 1'b0; iWrEn = 1'b0; iWrSel = '0; iWrReg = 1'b0; iWrData = '0;
    s_sync = 1'b0; s_wren = 1'b0; s_wrsel = 1'b0; s_wrreg = 1'b0; s_data = '0;

    repeat (3) step();
    check("reset_small_en", 32'(s_en), 32'd0);
    check("reset_small_run", 32'(s_run), 32'd1);
    iRst = 1'b0;

    // 1000 adds at 122/1024 -> floor(1000*122/1024) = 119 single-cycle pulses
    cnt = 0; prev = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step();
      cnt += int'(s_en);
      check("small_width", 32'(prev & s_en), 32'd0);
      prev = s_en;
    end
    check("small_pulse_count", 32'(cnt), 32'd119);

    // Half-scale increment: pulse every 2nd add, square wave period 4
    wr(0, 1'b0, 16'h8000);
    wr(0, 1'b1, 16'h0000);
    wr(0, 1'b1, 16'h0001);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("half_rate_en", 32'(oClkEn[0]), 32'((k % 2) == 0));
    end

    // Increment write on a carry edge: pulse still emitted, new rate thereafter
    step();
    wr(0, 1'b0, 16'h4000);
    check("wr_on_carry_en", 32'(oClkEn[0]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("wr_on_carry_new", 32'(oClkEn[0]), 32'(k == 4));
    end

    // Oneshot on ch1
    wr(1, 1'b0, 16'h4000);
    wr(1, 1'b1, 16'h0000);
    wr(1, 1'b1, 16'h0003);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("oneshot_en", 32'(oClkEn[1]), 32'(k == 4));
      check("oneshot_run", 32'(oRunning[1]), 32'(k < 4));
    end

    // Sync aligns ch0 and ch2 running at equal increments
    wr(0, 1'b0, 16'd7820);
    repeat (3) step();
    iSync = 1'b1; step(); iSync = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      a = (longint'(k) * 7820) / MOD;
      b = (longint'(k - 1) * 7820) / MOD;
      check("sync_ch0", 32'(oClkEn[0]), 32'(a != b));
      check("sync_ch2", 32'(oClkEn[2]), 32'(a != b));
    end

    // Ignored out-of-range write
    wr(3, 1'b1, 16'h0000);
    wr(3, 1'b0, 16'h0000);

    // Reset overrides sync and writes
    iRst = 1'b1; iSync = 1'b1; iWrEn = 1'b1; iWrSel = 2'd0; iWrReg = 1'b1; iWrData = 16'h0;
    repeat (2) step();
    check("rst_override_run", 32'(oRunning), 32'h7);
    check("rst_override_en", 32'(oClkEn), 32'h0);
    iRst = 1'b0; iSync = 1'b0; iWrEn = 1'b0;

    for (int k = 0; k < 4000; k++) begin
      iRst    = ($urandom_range(0, 299) == 0);
      iSync   = ($urandom_range(0, 24) == 0);
      iWrEn   = ($urandom_range(0, 4) == 0);
      iWrSel  = 2'($urandom_range(0, 3));
      iWrReg  = 1'($urandom_range(0, 1));
      if (iWrReg) begin
        iWrData = 16'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 5))
          0:       iWrData = 16'h0000;
          1:       iWrData = 16'h8000;
          2:       iWrData = 16'h4000;
          3:       iWrData = 16'hffff;
          4:       iWrData = 16'($urandom_range(1, 4000));
          default: iWrData = 16'($urandom);
        endcase
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule
